// File: rtl/sb_commit_tracker_if.sv
// Issue / completion / retire bundle for the scoreboard commit tracker.
interface sb_commit_tracker_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PCW   = 64
) ();
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic           flush;
  logic           issue_valid;
  logic [PCW-1:0] issue_pc;
  logic           issue_ready;
  logic           ao_done_valid;
  logic [PCW-1:0] ao_done_pc;
  logic           at_done_valid;
  logic [PCW-1:0] at_done_pc;
  logic           mm_done_valid;
  logic [PCW-1:0] mm_done_pc;
  logic [PCW-1:0] sb_pc;
  logic           retire_valid;
  logic [PCW-1:0] retire_pc;
  logic [CW-1:0]  count;
  logic           empty;
  logic           full;
  logic           unmatched_err;

  // Pipeline side: drives issue/completions, observes tracker state.
  modport master (
    output flush, issue_valid, issue_pc,
    output ao_done_valid, ao_done_pc, at_done_valid, at_done_pc,
    output mm_done_valid, mm_done_pc,
    input  issue_ready, sb_pc, retire_valid, retire_pc,
    input  count, empty, full, unmatched_err
  );

  // Tracker side.
  modport slave (
    input  flush, issue_valid, issue_pc,
    input  ao_done_valid, ao_done_pc, at_done_valid, at_done_pc,
    input  mm_done_valid, mm_done_pc,
    output issue_ready, sb_pc, retire_valid, retire_pc,
    output count, empty, full, unmatched_err
  );
endinterface

// File: rtl/sb_commit_tracker.sv
// In-order commit tracker: circular queue of in-flight pcs, out-of-order
// completion marking from three units, in-order single retire per cycle.
module sb_commit_tracker #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PCW   = 64
) (
  input  logic               clk,
  input  logic               rst,
  sb_commit_tracker_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [PCW-1:0]   pc_q [DEPTH];
  logic [PCW-1:0]   pc_d [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             retire_valid_q, retire_valid_d;
  logic [PCW-1:0]   retire_pc_q, retire_pc_d;
  logic [PCW-1:0]   last_pc_q, last_pc_d;
  logic             err_q, err_d;

  logic             full_c;
  logic             issue_fire_c;
  logic             retire_c;
  logic [DEPTH-1:0] ao_hit_c, at_hit_c, mm_hit_c;

  assign full_c       = (count_q == CW'(DEPTH));
  assign issue_fire_c = bus.issue_valid && !full_c;
  assign retire_c     = valid_q[head_q] && done_q[head_q];

  assign bus.issue_ready   = !full_c;
  assign bus.full          = full_c;
  assign bus.empty         = (count_q == '0);
  assign bus.count         = count_q;
  assign bus.sb_pc         = (count_q != '0) ? pc_q[head_q] : last_pc_q;
  assign bus.retire_valid  = retire_valid_q;
  assign bus.retire_pc     = retire_pc_q;
  assign bus.unmatched_err = err_q;

  // CAM match of each completion port against valid entries; the slot being
  // written by issue this cycle is never a match candidate.
  always_comb begin
    ao_hit_c = '0;
    at_hit_c = '0;
    mm_hit_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !(issue_fire_c && (tail_q == AW'(i)))) begin
        ao_hit_c[i] = bus.ao_done_valid && (pc_q[i] == bus.ao_done_pc);
        at_hit_c[i] = bus.at_done_valid && (pc_q[i] == bus.at_done_pc);
        mm_hit_c[i] = bus.mm_done_valid && (pc_q[i] == bus.mm_done_pc);
      end
    end
  end

  // Next-state: flush wipes the queue; otherwise mark, retire, then issue.
  always_comb begin
    valid_d        = valid_q;
    done_d         = done_q;
    pc_d           = pc_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    retire_valid_d = 1'b0;
    retire_pc_d    = retire_pc_q;
    last_pc_d      = last_pc_q;
    err_d          = err_q;

    if (bus.flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      done_d = done_q | ao_hit_c | at_hit_c | mm_hit_c;
      if ((bus.ao_done_valid && (ao_hit_c == '0)) ||
          (bus.at_done_valid && (at_hit_c == '0)) ||
          (bus.mm_done_valid && (mm_hit_c == '0))) begin
        err_d = 1'b1;
      end

      if (retire_c) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + AW'(1);
        retire_valid_d  = 1'b1;
        retire_pc_d     = pc_q[head_q];
        last_pc_d       = pc_q[head_q];
      end

      if (issue_fire_c) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        pc_d[tail_q]    = bus.issue_pc;
        tail_d          = tail_q + AW'(1);
      end

      count_d = count_q + CW'(issue_fire_c) - CW'(retire_c);
    end
  end

  // State registers; reset discards everything without a retire pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      retire_valid_q <= 1'b0;
      retire_pc_q    <= '0;
      last_pc_q      <= '0;
      err_q          <= 1'b0;
      for (int i = 0; i < DEPTH; i++) pc_q[i] <= '0;
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      retire_valid_q <= retire_valid_d;
      retire_pc_q    <= retire_pc_d;
      last_pc_q      <= last_pc_d;
      err_q          <= err_d;
      for (int i = 0; i < DEPTH; i++) pc_q[i] <= pc_d[i];
    end
  end
endmodule

// File: tb/tb_sb_commit_tracker.sv
// Bench for sb_commit_tracker: constant vector table, hand-written corner
// sequences and a randomized run against an in-order queue model.
module tb_sb_commit_tracker;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PCW   = 64;

  typedef struct {
    bit          rst;
    bit          flush;
    bit          iv;
    logic [63:0] ipc;
    bit          av;
    logic [63:0] apc;
    bit          tv;
    logic [63:0] tpc;
    bit          mv;
    logic [63:0] mpc;
  } stim_t;

  typedef struct {
    stim_t       s;
    int          ecount;
    bit          erv;
    logic [63:0] erpc;
    logic [63:0] esb;
    bit          eerr;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    bit          done;
  } ment_t;

  logic clk;
  logic rst;
  sb_commit_tracker_if #(.DEPTH(DEPTH), .PCW(PCW)) bus ();

  sb_commit_tracker #(.DEPTH(DEPTH), .PCW(PCW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: ordered list of in-flight instructions.
  ment_t       mq[$];
  logic [63:0] m_last = '0;
  logic [63:0] m_rpc  = '0;
  bit          m_rv   = 1'b0;
  bit          m_err  = 1'b0;
  logic [63:0] ret_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(bit fl, bit iv, logic [63:0] ipc,
                               bit av, logic [63:0] apc, bit tv, logic [63:0] tpc,
                               bit mv, logic [63:0] mpc);
    stim_t s;
    s.rst = 1'b0; s.flush = fl; s.iv = iv; s.ipc = ipc;
    s.av = av; s.apc = apc; s.tv = tv; s.tpc = tpc; s.mv = mv; s.mpc = mpc;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic stim_t iss(logic [63:0] pc);
    return mk(0, 1, pc, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic stim_t rst_s();
    stim_t s = idle();
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic vec_t vv(stim_t s, int c, bit rv, logic [63:0] rpc,
                              logic [63:0] sb, bit err);
    vec_t v;
    v.s = s; v.ecount = c; v.erv = rv; v.erpc = rpc; v.esb = sb; v.eerr = err;
    return v;
  endfunction

  // Apply one completion to the model: mark every matching in-flight entry.
  function automatic void model_done(logic [63:0] pc);
    bit hit = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].pc == pc) begin
        mq[i].done = 1'b1;
        hit = 1'b1;
      end
    end
    if (!hit) m_err = 1'b1;
  endfunction

  function automatic void model_step(stim_t s);
    bit was_full;
    bit ret;
    ment_t e;
    if (s.rst) begin
      mq.delete(); m_last = '0; m_rpc = '0; m_rv = 1'b0; m_err = 1'b0;
      return;
    end
    if (s.flush) begin
      mq.delete(); m_rv = 1'b0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    ret = (mq.size() > 0) && mq[0].done;
    if (s.av) model_done(s.apc);
    if (s.tv) model_done(s.tpc);
    if (s.mv) model_done(s.mpc);
    m_rv = ret;
    if (ret) begin
      m_rpc  = mq[0].pc;
      m_last = mq[0].pc;
      void'(mq.pop_front());
    end
    if (s.iv && !was_full) begin
      e.pc = s.ipc; e.done = 1'b0;
      mq.push_back(e);
    end
  endfunction

  task automatic check_model();
    int n = mq.size();
    chk("m_count", 64'(bus.count), 64'(n));
    chk("m_empty", 64'(bus.empty), 64'(n == 0));
    chk("m_full", 64'(bus.full), 64'(n == DEPTH));
    chk("m_issue_ready", 64'(bus.issue_ready), 64'(n != DEPTH));
    chk("m_sb_pc", bus.sb_pc, (n != 0) ? mq[0].pc : m_last);
    chk("m_retire_valid", 64'(bus.retire_valid), 64'(m_rv));
    chk("m_retire_pc", bus.retire_pc, m_rpc);
    chk("m_unmatched_err", 64'(bus.unmatched_err), 64'(m_err));
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, compare at negedge.
  task automatic step(input stim_t s);
    rst               = s.rst;
    bus.flush         = s.flush;
    bus.issue_valid   = s.iv;
    bus.issue_pc      = s.ipc;
    bus.ao_done_valid = s.av;
    bus.ao_done_pc    = s.apc;
    bus.at_done_valid = s.tv;
    bus.at_done_pc    = s.tpc;
    bus.mm_done_valid = s.mv;
    bus.mm_done_pc    = s.mpc;
    @(posedge clk);
    model_step(s);
    @(negedge clk);
    if (bus.retire_valid) ret_log.push_back(bus.retire_pc);
    check_model();
  endtask

  vec_t tbl[26];

  initial begin
    stim_t s;
    logic [63:0] pc_gen;

    // Fixed vectors: in-order retire, 3-port same-cycle completion, flush, unmatched.
    tbl[0]  = vv(iss(64'h8000_0000), 1, 0, 0, 64'h8000_0000, 0);
    tbl[1]  = vv(iss(64'h8000_0004), 2, 0, 0, 64'h8000_0000, 0);
    tbl[2]  = vv(iss(64'h8000_0008), 3, 0, 0, 64'h8000_0000, 0);
    tbl[3]  = vv(mk(0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_0008), 3, 0, 0, 64'h8000_0000, 0);
    tbl[4]  = vv(mk(0, 0, 0, 0, 0, 1, 64'h8000_0004, 0, 0), 3, 0, 0, 64'h8000_0000, 0);
    tbl[5]  = vv(mk(0, 0, 0, 1, 64'h8000_0000, 0, 0, 0, 0), 3, 0, 0, 64'h8000_0000, 0);
    tbl[6]  = vv(idle(), 2, 1, 64'h8000_0000, 64'h8000_0004, 0);
    tbl[7]  = vv(idle(), 1, 1, 64'h8000_0004, 64'h8000_0008, 0);
    tbl[8]  = vv(idle(), 0, 1, 64'h8000_0008, 64'h8000_0008, 0);
    tbl[9]  = vv(idle(), 0, 0, 0, 64'h8000_0008, 0);
    tbl[10] = vv(iss(64'h100), 1, 0, 0, 64'h100, 0);
    tbl[11] = vv(iss(64'h104), 2, 0, 0, 64'h100, 0);
    tbl[12] = vv(iss(64'h108), 3, 0, 0, 64'h100, 0);
    tbl[13] = vv(mk(0, 0, 0, 1, 64'h104, 1, 64'h108, 1, 64'h100), 3, 0, 0, 64'h100, 0);
    tbl[14] = vv(idle(), 2, 1, 64'h100, 64'h104, 0);
    tbl[15] = vv(idle(), 1, 1, 64'h104, 64'h108, 0);
    tbl[16] = vv(idle(), 0, 1, 64'h108, 64'h108, 0);
    tbl[17] = vv(iss(64'h8000_0000), 1, 0, 0, 64'h8000_0000, 0);
    tbl[18] = vv(iss(64'h8000_0004), 2, 0, 0, 64'h8000_0000, 0);
    tbl[19] = vv(iss(64'h8000_0008), 3, 0, 0, 64'h8000_0000, 0);
    tbl[20] = vv(iss(64'h8000_000C), 4, 0, 0, 64'h8000_0000, 0);
    tbl[21] = vv(iss(64'h8000_0010), 5, 0, 0, 64'h8000_0000, 0);
    tbl[22] = vv(mk(1, 0, 0, 1, 64'h8000_0000, 0, 0, 0, 0), 0, 0, 0, 64'h108, 0);
    tbl[23] = vv(idle(), 0, 0, 0, 64'h108, 0);
    tbl[24] = vv(mk(0, 0, 0, 1, 64'h1234_5678, 0, 0, 0, 0), 0, 0, 0, 64'h108, 1);
    tbl[25] = vv(idle(), 0, 0, 0, 64'h108, 1);

    step(rst_s());
    step(rst_s());
    chk("rst_count", 64'(bus.count), 0);
    chk("rst_empty", 64'(bus.empty), 1);
    chk("rst_full", 64'(bus.full), 0);
    chk("rst_ready", 64'(bus.issue_ready), 1);
    chk("rst_retire_valid", 64'(bus.retire_valid), 0);
    chk("rst_retire_pc", bus.retire_pc, 0);
    chk("rst_sb_pc", bus.sb_pc, 0);
    chk("rst_err", 64'(bus.unmatched_err), 0);

    for (int r = 0; r < 26; r++) begin
      step(tbl[r].s);
      chk($sformatf("v%0d_count", r), 64'(bus.count), 64'(tbl[r].ecount));
      chk($sformatf("v%0d_empty", r), 64'(bus.empty), 64'(tbl[r].ecount == 0));
      chk($sformatf("v%0d_full", r), 64'(bus.full), 64'(tbl[r].ecount == DEPTH));
      chk($sformatf("v%0d_retire_valid", r), 64'(bus.retire_valid), 64'(tbl[r].erv));
      if (tbl[r].erv) chk($sformatf("v%0d_retire_pc", r), bus.retire_pc, tbl[r].erpc);
      chk($sformatf("v%0d_sb_pc", r), bus.sb_pc, tbl[r].esb);
      chk($sformatf("v%0d_err", r), 64'(bus.unmatched_err), 64'(tbl[r].eerr));
    end
    step(rst_s());
    chk("rst_clears_err", 64'(bus.unmatched_err), 0);
    chk("rst_clears_last", bus.sb_pc, 0);

    // Full queue: ninth issue dropped; a retire at full does not admit an issue.
    for (int i = 0; i < DEPTH; i++) step(iss(64'h200 + 64'(4 * i)));
    chk("full_full", 64'(bus.full), 1);
    chk("full_ready", 64'(bus.issue_ready), 0);
    chk("full_count", 64'(bus.count), 8);
    step(mk(0, 1, 64'h300, 1, 64'h200, 0, 0, 0, 0));
    chk("full_drop_count", 64'(bus.count), 8);
    step(iss(64'h300));
    chk("full_retire_valid", 64'(bus.retire_valid), 1);
    chk("full_retire_pc", bus.retire_pc, 64'h200);
    chk("full_retire_no_admit", 64'(bus.count), 7);
    step(iss(64'h300));
    chk("full_refill", 64'(bus.count), 8);
    step(mk(0, 0, 0, 1, 64'h204, 0, 0, 0, 0));
    step(idle());
    chk("full_retire2", 64'(bus.count), 7);
    step(mk(0, 0, 0, 0, 0, 1, 64'h208, 0, 0));
    step(iss(64'h304));
    chk("issue_retire_balance", 64'(bus.count), 7);
    chk("issue_retire_pc", bus.retire_pc, 64'h208);

    // Reset mid-flight while the head is ready to retire.
    step(rst_s());
    step(iss(64'h500));
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 64'h500));
    step(rst_s());
    chk("midrst_no_retire", 64'(bus.retire_valid), 0);
    chk("midrst_count", 64'(bus.count), 0);
    step(idle());
    chk("midrst_no_retire_late", 64'(bus.retire_valid), 0);

    // Wrap-around: 20 issue/complete pairs, retire order must equal issue order.
    ret_log.delete();
    for (int k = 0; k < 20; k++) begin
      s = iss(64'h1000 + 64'(4 * k));
      if (k > 0) begin
        s.av = 1'b1; s.apc = 64'h1000 + 64'(4 * (k - 1));
      end
      step(s);
    end
    step(mk(0, 0, 0, 0, 0, 1, 64'h1000 + 64'(4 * 19), 0, 0));
    for (int k = 0; k < 3; k++) step(idle());
    chk("wrap_retire_count", 64'(ret_log.size()), 20);
    for (int k = 0; k < 20; k++) begin
      if (k < ret_log.size())
        chk($sformatf("wrap_order%0d", k), ret_log[k], 64'h1000 + 64'(4 * k));
    end
    chk("wrap_empty", 64'(bus.empty), 1);

    // Randomized traffic against the model.
    pc_gen = 64'h4000_0000_0000_0000;
    for (int c = 0; c < 3000; c++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 499) == 0);
      s.flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) begin
        pc_gen = pc_gen + 64'(4 * $urandom_range(1, 3));
        s.iv = 1'b1; s.ipc = pc_gen;
      end
      for (int p = 0; p < 3; p++) begin
        bit v = 1'b0;
        logic [63:0] pc = '0;
        if ($urandom_range(0, 2) == 0) begin
          if (mq.size() > 0 && $urandom_range(0, 63) != 0) begin
            v = 1'b1; pc = mq[$urandom_range(0, mq.size() - 1)].pc;
          end else if ($urandom_range(0, 7) == 0) begin
            v = 1'b1; pc = {$urandom, $urandom};
          end
        end
        if (p == 0) begin s.av = v; s.apc = pc; end
        else if (p == 1) begin s.tv = v; s.tpc = pc; end
        else begin s.mv = v; s.mpc = pc; end
      end
      step(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
